// File: rtl/ext_arbiter.sv
// Shares one combinational immediate extender between two requesters, round-robin on ties.
// Latency: request edge -> ack two cycles later; one result per 2 cycles when alternating, per 3 for one requester.
module ext_arbiter #(
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic [IMM_W-1:0]  imm0,
   input  logic [1:0]        eop0,
   output logic              ack0,
   output logic [DATA_W-1:0] res0,
   input  logic              req1,
   input  logic [IMM_W-1:0]  imm1,
   input  logic [1:0]        eop1,
   output logic              ack1,
   output logic [DATA_W-1:0] res1,
   output logic [IMM_W-1:0]  ext_imm,
   output logic [1:0]        ext_EOp,
   input  logic [DATA_W-1:0] ext_in,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                grant_q, grant_d;
   logic                last_grant_q, last_grant_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic [DATA_W-1:0]   res0_q, res0_d;
   logic [DATA_W-1:0]   res1_q, res1_d;
   logic [IMM_W-1:0]    ext_imm_q, ext_imm_d;
   logic [1:0]          ext_eop_q, ext_eop_d;
   logic                busy_q, busy_d;
   logic                pick;
   logic                other_req;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      res0_d       = res0_q;
      res1_d       = res1_q;
      ext_imm_d    = ext_imm_q;
      ext_eop_d    = ext_eop_q;
      pick         = 1'b0;
      other_req    = 1'b0;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // On a tie the requester that did not win last time goes next.
               pick         = (req0 && req1) ? ~last_grant_q : req1;
               grant_d      = pick;
               last_grant_d = pick;
               ext_imm_d    = pick ? imm1 : imm0;
               ext_eop_d    = pick ? eop1 : eop0;
               state_d      = LAUNCH;
            end
         end
         LAUNCH: begin
            if (grant_q) begin
               res1_d = ext_in;
               ack1_d = 1'b1;
            end else begin
               res0_d = ext_in;
               ack0_d = 1'b1;
            end
            state_d = DONE;
         end
         DONE: begin
            // The just-acked requester is ignored here so a lingering req cannot double-fire.
            pick      = ~grant_q;
            other_req = grant_q ? req0 : req1;
            if (other_req) begin
               grant_d      = pick;
               last_grant_d = pick;
               ext_imm_d    = pick ? imm1 : imm0;
               ext_eop_d    = pick ? eop1 : eop0;
               state_d      = LAUNCH;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         res0_q       <= '0;
         res1_q       <= '0;
         ext_imm_q    <= '0;
         ext_eop_q    <= 2'b00;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         res0_q       <= res0_d;
         res1_q       <= res1_d;
         ext_imm_q    <= ext_imm_d;
         ext_eop_q    <= ext_eop_d;
         busy_q       <= busy_d;
      end
   end

   assign ack0    = ack0_q;
   assign ack1    = ack1_q;
   assign res0    = res0_q;
   assign res1    = res1_q;
   assign ext_imm = ext_imm_q;
   assign ext_EOp = ext_eop_q;
   assign busy    = busy_q;

endmodule

// File: doc/ext_arbiter.md
Name: ext_arbiter

Overview:
- Shares one combinational immediate extender (`ext`) between two requesters, e.g. the decode stage and the branch/jump offset path.
- Latches the selected request, drives the extender's `imm`/`EOp` inputs, and captures the 32-bit `ext` result.
- Returns the result to the granted requester with a one-cycle `ack` pulse.
- Sits beside `ext` in the datapath; the extender itself is instantiated outside this block.

Parameters:
IMM_W  16  width of the immediate field
DATA_W  32  width of the extended result

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-low reset (0 = reset)
req0  input  1  requester 0 request, level; held until ack0
imm0  input  IMM_W  requester 0 immediate
eop0  input  2  requester 0 extension op
ack0  output  1  one-cycle pulse: res0 valid
res0  output  DATA_W  requester 0 result
req1  input  1  requester 1 request, level; held until ack1
imm1  input  IMM_W  requester 1 immediate
eop1  input  2  requester 1 extension op
ack1  output  1  one-cycle pulse: res1 valid
res1  output  DATA_W  requester 1 result
ext_imm  output  IMM_W  to extender `imm`
ext_EOp  output  2  to extender `EOp`
ext_in  input  DATA_W  from extender `ext` (combinational)
busy  output  1  1 in LAUNCH or DONE

Behaviour:
- Reset (reset=0 at a rising edge) clears everything on that edge, regardless of state:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - ack0=ack1=0, res0=res1=0, ext_imm=0, ext_EOp=0, busy=0.
- Reset mid-operation aborts the operation; no ack is issued.
- EOp encoding of the extender:
  - 00: sign-extend.
  - 01: zero-extend.
  - 10: imm<<16.
  - 11: sign-extend then <<2.
- The arbiter passes all four codes through unchanged and performs no arithmetic itself.
- FSM states: IDLE, LAUNCH, DONE.
- IDLE:
  - With any req high at an edge, pick a winner, register `imm`/`eop` into ext_imm/ext_EOp, record grant and last_grant, go to LAUNCH.
  - With no req high, stay in IDLE.
- Arbitration:
  - Only one req high: grant it.
  - Both high: grant the requester != last_grant (round-robin).
- LAUNCH:
  - ext_imm/ext_EOp are stable for the whole cycle.
  - At the edge, capture ext_in into res of the granted requester only; the other res is unchanged.
  - Assert that requester's ack for the next cycle; go to DONE.
- DONE:
  - ack of the granted requester is 1 for exactly this cycle.
  - The acked requester's req is masked at this edge; it must deassert in this cycle or it is treated as a new request from the next edge.
  - Other requester's req high at this edge: grant it, latch its operands, go to LAUNCH (back-to-back).
  - Otherwise go to IDLE.
- Latency: req rising seen at edge N -> LAUNCH during cycle N..N+1 -> ack high in cycle N+1..N+2. ack occurs 2 cycles after the request edge.
- Throughput:
  - 1 result per 2 cycles when the two requesters alternate.
  - 1 per 3 cycles for a single requester issuing repeatedly.
- res0/res1 hold their value until that requester's next capture.
- ack0 and ack1 are never high simultaneously.
- Operands sampled at grant are used even if the requester changes imm/eop afterwards. Requesters must hold them stable until ack anyway.
- ext_imm/ext_EOp hold their last latched value in IDLE and DONE.
- Requester protocol: a req is never withdrawn before its ack. A withdrawn req is still served once granted.

Test Plan:
1. Reset with req0=1 held → all outputs 0, state IDLE. Release reset → first grant to req0; ack0 pulses 2 cycles later.
2. req0=1, imm0=0x8000, eop0 swept 00/01/10/11 (one request each, req dropped after ack) → res0 = 0xFFFF8000 / 0x00008000 / 0x80000000 / 0xFFFE0000.
3. req0 and req1 raised together (imm0=0x0004, eop0=01; imm1=0xFFFF, eop1=00) → ack0 first with res0=0x00000004. ack1 follows 2 cycles later with res1=0xFFFFFFFF. res0 is unchanged at ack1.
4. Both requesters re-request immediately after each ack for 8 ops → grants alternate 0,1,0,1…, one ack every 2 cycles, ack0 and ack1 never overlapping.
5. reset=0 asserted during LAUNCH of a req1 op → no ack1, res1 stays 0, busy=0 next cycle. After release with req1 still high, the op restarts and completes.
6. req1 kept high one cycle past ack1, with no req0 → masked at the DONE edge, then regranted from IDLE. A second ack1 arrives 3 cycles after the first.
